clk_cfg_seq: RTL and testbench
==============================

Name: clk_cfg_seq

Overview:
Sequencer between the core's clock configuration register and the Altera clock generator. It takes the raw CLK register value written by the core and releases it to the clock generator in a safe order:
- enable the oscillator/PLL first;
- wait a settle time;
- gate the cog clock around the CLKSEL switch;
- drop enables last.

It also turns the CLK RESET bit into a timed soft-reset pulse that is OR-ed into the core reset at top level.

Parameters:
SETTLE_CYCLES, 1600000, clock cycles to wait after newly enabling OSC or PLL (10 ms at 160 MHz)
GAP_CYCLES, 4, cycles clk_gate is held low before and after a CLKSEL change
RES_CYCLES, 16, length of soft_res pulse in clock cycles

Ports:
clock  input  1  fixed 160 MHz clock (same domain as the reset generator)
res  input  1  synchronous active-high reset
cfg_req  input  8  CLK register from core: [7]=RESET, [6]=PLLENA, [5]=OSCENA, [4:3]=OSCM, [2:0]=CLKSEL
cfg_out  output  7  applied config to clock generator, same bit layout as cfg_req[6:0]
clk_gate  output  1  cog clock enable; 0 = clock generator holds clk_cog/clk_pll low
busy  output  1  a sequence is in progress
soft_res  output  1  soft reset pulse requested via cfg_req[7]
cfg_err  output  1  illegal request pulse (only with CFG_CHECK_EN; otherwise tied 0)

Behaviour:
- Interface: one clock, `clock`; reset `res` is synchronous and active-high. All outputs are registered.
- Values while and after res: cfg_out=7'h00 (RCFAST), clk_gate=1, busy=0, soft_res=0, cfg_err=0, state IDLE, all counters 0.
- A res asserted mid-sequence aborts the sequence. Outputs take reset values the cycle after res is sampled.
- States: IDLE, SETTLE, GAP_PRE, SWITCH, GAP_POST.
- IDLE:
  - Each cycle compare cfg_req[6:0] with cfg_out. On mismatch, latch pend<=cfg_req[6:0] and set busy=1 in the next cycle.
  - add = pend[6:5] & ~cfg_out[6:5].
  - If add != 0: cfg_out[6:3] <= {cfg_out[6:5]|add, pend[4:3]} (new enables only, nothing dropped, CLKSEL kept). Load timer with SETTLE_CYCLES-1. Go to SETTLE.
  - Else if pend[2:0] != cfg_out[2:0]: go to GAP_PRE.
  - Else: cfg_out <= pend. Stay IDLE, with busy high for that one cycle.
- SETTLE: the timer counts down. At 0, go to GAP_PRE if CLKSEL differs; otherwise cfg_out <= pend and go to IDLE.
- GAP_PRE: clk_gate=0 for GAP_CYCLES cycles, then go to SWITCH.
- SWITCH: one cycle, clk_gate=0. cfg_out[2:0] <= pend[2:0]. Go to GAP_POST.
- GAP_POST: clk_gate=0 for GAP_CYCLES cycles. On exit, cfg_out <= pend (drops any disabled enables), clk_gate=1, busy=0, go to IDLE.
- Changes to cfg_req while busy are ignored. Back in IDLE they are re-compared, so the last written value wins and there is no queue.
- GAP_CYCLES=0 is legal: GAP_PRE and GAP_POST are skipped and SWITCH still gates for 1 cycle.
- Timer width is $clog2(SETTLE_CYCLES+1); it must not wrap.
- soft_res:
  - A rising edge on cfg_req[7] (previous value registered) sets soft_res=1 for exactly RES_CYCLES cycles, in any state.
  - A new edge during the pulse restarts the count.
  - It does not affect the config sequence.

Optional Feature:
CLK_CFG_CHECK_EN
- Defined: in IDLE, a mismatched request is legal only if its enables cover its CLKSEL:
  - CLKSEL=2 needs OSCENA;
  - CLKSEL 3..7 need OSCENA and PLLENA.
  An illegal request is not latched and cfg_out is unchanged. cfg_err pulses for 1 cycle and re-arms only after cfg_req changes.
- Undefined: no check; cfg_err is tied 0. Illegal values pass through using the normal sequence.

Decomposition:
- Package clk_cfg_pkg:
  - bit-position localparams: RESET=7, PLLENA=6, OSCENA=5, OSCM_HI=4, OSCM_LO=3, SEL_HI=2, SEL_LO=0;
  - typedef enum clksel_t: RCFAST, RCSLOW, XINPUT, XPLL1, XPLL2, XPLL4, XPLL8, XPLL16;
  - typedef enum seq_state_t;
  - function sel_needs(clksel) returning the required {PLLENA, OSCENA}.
- One sub-module, seq_timer: a loadable down-counter with a zero flag, shared by SETTLE and both gap states.

Test Plan:
1. Reset check: hold res 3 cycles, release -> cfg_out=00, clk_gate=1, busy=0, soft_res=0 on the first cycle after release.
2. Enable and switch (SETTLE_CYCLES=100, GAP_CYCLES=4): cfg_req 00 -> 6F.
   - The cycle after, busy=1 and cfg_out=68.
   - After 100 cycles, clk_gate low 4 cycles, then cfg_out=6F in SWITCH.
   - clk_gate low 4 more cycles, then clk_gate=1, busy=0.
3. Switch down: from 6F, cfg_req -> 00.
   - No settle; clk_gate low 4+1+4 cycles.
   - cfg_out=68 in SWITCH, then 00 on exit.
4. Soft reset: cfg_req[7] 0->1 (RES_CYCLES=16) -> soft_res high exactly 16 cycles.
   - Holding bit 7 high does not retrigger.
   - Toggling it at cycle 10 extends the pulse to cycle 26.
5. Reset mid-sequence: assert res at SETTLE cycle 50 -> the next cycle shows cfg_out=00, busy=0, clk_gate=1, and no later switch.
6. CLK_CFG_CHECK_EN: cfg_req 00 -> 03 -> cfg_err single-cycle pulse, busy stays 0, cfg_out stays 00. Then 63 -> the normal sequence completes with cfg_out=63.

Source files
------------

// File: rtl/clk_cfg_pkg.sv
// Shared definitions for the clock configuration sequencer: CLK register
// bit positions, CLKSEL encodings, sequencer states and the enable
// requirement of each clock source.
package clk_cfg_pkg;

   localparam int RESET   = 7;
   localparam int PLLENA  = 6;
   localparam int OSCENA  = 5;
   localparam int OSCM_HI = 4;
   localparam int OSCM_LO = 3;
   localparam int SEL_HI  = 2;
   localparam int SEL_LO  = 0;

   typedef enum logic [2:0] {
      RCFAST, RCSLOW, XINPUT, XPLL1, XPLL2, XPLL4, XPLL8, XPLL16
   } clksel_t;

   typedef enum logic [2:0] {
      IDLE, SETTLE, GAP_PRE, SWITCH, GAP_POST
   } seq_state_t;

   // Enables a clock source needs, returned as {PLLENA, OSCENA}.
   function automatic logic [1:0] sel_needs(input clksel_t sel);
      case (sel)
         RCFAST, RCSLOW: sel_needs = 2'b00;
         XINPUT:         sel_needs = 2'b01;
         default:        sel_needs = 2'b11;
      endcase
   endfunction

endpackage

// File: rtl/clk_cfg_seq_timer.sv
// Loadable down-counter with a zero flag. Holds at zero instead of wrapping.
module seq_timer #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         res,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   // Load takes priority; otherwise count down and stop at zero.
   always_ff @(posedge clock) begin
      if (res)                r_cnt <= '0;
      else if (i_load)        r_cnt <= i_val;
      else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_cfg_seq.sv
// Clock configuration sequencer. Applies the core's CLK register to the
// clock generator in a safe order (enable, settle, gated CLKSEL switch,
// drop enables) and turns a rising CLK RESET bit into a soft-reset pulse.
// Optional legality check of requested CLKSEL vs. enables: CLK_CFG_CHECK_EN.
module clk_cfg_seq
   import clk_cfg_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1600000,
   parameter int GAP_CYCLES    = 4,
   parameter int RES_CYCLES    = 16
) (
   input  logic       clock,
   input  logic       res,
   input  logic [7:0] cfg_req,
   output logic [6:0] cfg_out,
   output logic       clk_gate,
   output logic       busy,
   output logic       soft_res,
   output logic       cfg_err
);

   localparam int TMAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int RW   = $clog2(RES_CYCLES + 1);
   localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LD    = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [RW-1:0] RES_LD    = RW'(RES_CYCLES - 1);

   seq_state_t    r_state, w_nxt_state;
   logic [6:0]    r_cfg, w_nxt_cfg;
   logic [6:0]    r_pend, w_nxt_pend;
   logic          r_gate, w_nxt_gate;
   logic          r_busy, w_nxt_busy;
   logic          w_ld, w_zero;
   logic [TW-1:0] w_ld_val;
   logic [6:0]    w_req, w_tgt;
   logic [1:0]    w_add;

   assign w_req = cfg_req[PLLENA:SEL_LO];
   assign w_add = w_req[PLLENA:OSCENA] & ~r_cfg[PLLENA:OSCENA];
   // Target of a gap sequence: the live request when starting from IDLE,
   // the latched one when coming out of SETTLE.
   assign w_tgt = (r_state == IDLE) ? w_req : r_pend;

`ifdef CLK_CFG_CHECK_EN
   logic [1:0] w_need;
   logic       w_legal, w_flag;
   assign w_need  = sel_needs(clksel_t'(w_req[SEL_HI:SEL_LO]));
   assign w_legal = ((w_req[PLLENA:OSCENA] & w_need) == w_need);
`endif

   seq_timer #(.W(TW)) u_tmr (
      .clock  (clock),
      .res    (res),
      .i_load (w_ld),
      .i_val  (w_ld_val),
      .o_zero (w_zero)
   );

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cfg   = r_cfg;
      w_nxt_pend  = r_pend;
      w_nxt_gate  = r_gate;
      w_nxt_busy  = r_busy;
      w_ld        = 1'b0;
      w_ld_val    = '0;
`ifdef CLK_CFG_CHECK_EN
      w_flag      = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            w_nxt_busy = 1'b0;
            w_nxt_gate = 1'b1;
            if (w_req != r_cfg) begin
`ifdef CLK_CFG_CHECK_EN
               if (!w_legal) w_flag = 1'b1;
               else
`endif
               begin
                  w_nxt_pend = w_req;
                  w_nxt_busy = 1'b1;
                  if (w_add != 2'b00) begin
                     // Add new enables only; keep CLKSEL until after settle.
                     w_nxt_cfg[PLLENA:OSCM_LO] = {r_cfg[PLLENA:OSCENA] | w_add,
                                                  w_req[OSCM_HI:OSCM_LO]};
                     w_ld        = 1'b1;
                     w_ld_val    = SETTLE_LD;
                     w_nxt_state = SETTLE;
                  end else if (w_req[SEL_HI:SEL_LO] != r_cfg[SEL_HI:SEL_LO]) begin
                     w_nxt_gate = 1'b0;
                     if (GAP_CYCLES > 0) begin
                        w_ld        = 1'b1;
                        w_ld_val    = GAP_LD;
                        w_nxt_state = GAP_PRE;
                     end else begin
                        w_nxt_cfg[SEL_HI:SEL_LO] = w_tgt[SEL_HI:SEL_LO];
                        w_nxt_state              = SWITCH;
                     end
                  end else begin
                     w_nxt_cfg = w_req;
                  end
               end
            end
         end
         SETTLE: begin
            if (w_zero) begin
               if (r_pend[SEL_HI:SEL_LO] != r_cfg[SEL_HI:SEL_LO]) begin
                  w_nxt_gate = 1'b0;
                  if (GAP_CYCLES > 0) begin
                     w_ld        = 1'b1;
                     w_ld_val    = GAP_LD;
                     w_nxt_state = GAP_PRE;
                  end else begin
                     w_nxt_cfg[SEL_HI:SEL_LO] = w_tgt[SEL_HI:SEL_LO];
                     w_nxt_state              = SWITCH;
                  end
               end else begin
                  w_nxt_cfg   = r_pend;
                  w_nxt_busy  = 1'b0;
                  w_nxt_state = IDLE;
               end
            end
         end
         GAP_PRE: begin
            if (w_zero) begin
               w_nxt_cfg[SEL_HI:SEL_LO] = r_pend[SEL_HI:SEL_LO];
               w_nxt_state              = SWITCH;
            end
         end
         SWITCH: begin
            if (GAP_CYCLES > 0) begin
               w_ld        = 1'b1;
               w_ld_val    = GAP_LD;
               w_nxt_state = GAP_POST;
            end else begin
               w_nxt_cfg   = r_pend;
               w_nxt_gate  = 1'b1;
               w_nxt_busy  = 1'b0;
               w_nxt_state = IDLE;
            end
         end
         GAP_POST: begin
            if (w_zero) begin
               // Disabled enables are dropped only here, after the switch.
               w_nxt_cfg   = r_pend;
               w_nxt_gate  = 1'b1;
               w_nxt_busy  = 1'b0;
               w_nxt_state = IDLE;
            end
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clock) begin
      if (res) begin
         r_state <= IDLE;
         r_cfg   <= 7'h00;
         r_pend  <= 7'h00;
         r_gate  <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_cfg   <= w_nxt_cfg;
         r_pend  <= w_nxt_pend;
         r_gate  <= w_nxt_gate;
         r_busy  <= w_nxt_busy;
      end
   end

   assign cfg_out  = r_cfg;
   assign clk_gate = r_gate;
   assign busy     = r_busy;

   logic          r_req7_d, r_soft;
   logic [RW-1:0] r_rcnt;
   logic          w_rise;
   assign w_rise = cfg_req[RESET] & ~r_req7_d;

   // Soft-reset pulse: each rising edge of the RESET bit (re)starts it.
   always_ff @(posedge clock) begin
      if (res) begin
         r_req7_d <= 1'b0;
         r_soft   <= 1'b0;
         r_rcnt   <= '0;
      end else begin
         r_req7_d <= cfg_req[RESET];
         if (w_rise) begin
            r_soft <= 1'b1;
            r_rcnt <= RES_LD;
         end else if (r_rcnt != '0) begin
            r_rcnt <= r_rcnt - 1'b1;
         end else begin
            r_soft <= 1'b0;
         end
      end
   end

   assign soft_res = r_soft;

`ifdef CLK_CFG_CHECK_EN
   logic       r_err, r_bad_vld;
   logic [6:0] r_bad;

   // One error pulse per illegal value; re-armed once cfg_req[6:0] moves off it.
   always_ff @(posedge clock) begin
      if (res) begin
         r_err     <= 1'b0;
         r_bad_vld <= 1'b0;
         r_bad     <= 7'h00;
      end else begin
         r_err <= w_flag & ~(r_bad_vld & (w_req == r_bad));
         if (w_flag) begin
            r_bad_vld <= 1'b1;
            r_bad     <= w_req;
         end else if (w_req != r_bad) begin
            r_bad_vld <= 1'b0;
         end
      end
   end

   assign cfg_err = r_err;
`else
   assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_clk_cfg_seq.sv
// Bench for clk_cfg_seq: directed scenarios followed by random requests,
// compared every cycle against a transaction-level reference model.
module tb_clk_cfg_seq;

   localparam int SETTLE = 100;
   localparam int GAP    = 4;
   localparam int RESC   = 16;
`ifdef CLK_CFG_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       res   = 1'b1;
   logic [7:0] cfg_req = 8'h00;
   logic [6:0] cfg_out;
   logic       clk_gate, busy, soft_res, cfg_err;

   always #5 clock = ~clock;

   clk_cfg_seq #(
      .SETTLE_CYCLES (SETTLE),
      .GAP_CYCLES    (GAP),
      .RES_CYCLES    (RESC)
   ) dut (
      .clock    (clock),
      .res      (res),
      .cfg_req  (cfg_req),
      .cfg_out  (cfg_out),
      .clk_gate (clk_gate),
      .busy     (busy),
      .soft_res (soft_res),
      .cfg_err  (cfg_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: an expected per-cycle trajectory queued per accepted request.
   typedef struct packed {
      logic [6:0] cfg;
      logic       gate;
      logic       busy;
   } exp_t;

   exp_t       q[$];
   exp_t       cur;
   int         soft_rem;
   bit         prev7;
   bit         armed;
   bit         exp_err;
   logic [6:0] prev_req;

   function automatic exp_t mk(input logic [6:0] c, input logic g, input logic b);
      exp_t e;
      e.cfg  = c;
      e.gate = g;
      e.busy = b;
      return e;
   endfunction

   function automatic bit legal(input logic [6:0] v);
      if (v[2:0] < 3'd2)  return 1'b1;
      if (v[2:0] == 3'd2) return v[5];
      return v[5] & v[6];
   endfunction

   task automatic plan(input logic [6:0] p);
      logic [6:0] c, base, sw;
      logic [1:0] add;
      c   = cur.cfg;
      add = p[6:5] & ~c[6:5];
      base = c;
      if (add != 2'b00) begin
         base = {c[6:5] | add, p[4:3], c[2:0]};
         repeat (SETTLE) q.push_back(mk(base, 1'b1, 1'b1));
      end
      if (p[2:0] != c[2:0]) begin
         sw = {base[6:3], p[2:0]};
         repeat (GAP) q.push_back(mk(base, 1'b0, 1'b1));
         q.push_back(mk(sw, 1'b0, 1'b1));
         repeat (GAP) q.push_back(mk(sw, 1'b0, 1'b1));
         q.push_back(mk(p, 1'b1, 1'b0));
      end else if (add != 2'b00) begin
         q.push_back(mk(p, 1'b1, 1'b0));
      end else begin
         q.push_back(mk(p, 1'b1, 1'b1));
      end
   endtask

   task automatic model_edge();
      exp_err = 1'b0;
      if (res) begin
         cur      = mk(7'h00, 1'b1, 1'b0);
         q.delete();
         soft_rem = 0;
         prev7    = 1'b0;
         armed    = 1'b1;
         prev_req = cfg_req[6:0];
         return;
      end
      if (cfg_req[7] && !prev7) soft_rem = RESC;
      else if (soft_rem > 0)    soft_rem--;
      prev7 = cfg_req[7];
      if (cfg_req[6:0] != prev_req) armed = 1'b1;
      prev_req = cfg_req[6:0];
      if (q.size() > 0) begin
         cur = q.pop_front();
      end else if (cfg_req[6:0] != cur.cfg) begin
         if (CHECK && !legal(cfg_req[6:0])) begin
            if (armed) begin
               exp_err = 1'b1;
               armed   = 1'b0;
            end
            cur.busy = 1'b0;
            cur.gate = 1'b1;
         end else begin
            plan(cfg_req[6:0]);
            cur = q.pop_front();
         end
      end else begin
         cur.busy = 1'b0;
         cur.gate = 1'b1;
      end
   endtask

   // One clock: step the model with the inputs seen at the edge, then compare.
   task automatic cyc();
      @(posedge clock);
      #1;
      model_edge();
      chk("cfg_out",  {25'd0, cfg_out}, {25'd0, cur.cfg});
      chk("clk_gate", {31'd0, clk_gate}, {31'd0, cur.gate});
      chk("busy",     {31'd0, busy},     {31'd0, cur.busy});
      chk("soft_res", {31'd0, soft_res}, {31'd0, soft_rem > 0});
      chk("cfg_err",  {31'd0, cfg_err},  {31'd0, exp_err});
   endtask

   initial begin
      // Reset held 3 cycles, then first cycle after release.
      res = 1'b1;
      repeat (3) cyc();
      res = 1'b0;
      cyc();

      // Enable and switch 00 -> 6F.
      cfg_req = 8'h6F;
      repeat (SETTLE + 2 * GAP + 10) cyc();

      // Switch down 6F -> 00, no settle.
      cfg_req = 8'h00;
      repeat (2 * GAP + 10) cyc();

      // Soft reset: held high, then retriggered around pulse cycle 10.
      cfg_req = 8'h80;
      repeat (9) cyc();
      cfg_req = 8'h00;
      cyc();
      cfg_req = 8'h80;
      repeat (30) cyc();
      cfg_req = 8'h00;
      repeat (3) cyc();

      // Reset in the middle of SETTLE.
      cfg_req = 8'h6F;
      repeat (50) cyc();
      res     = 1'b1;
      cfg_req = 8'h00;
      cyc();
      res = 1'b0;
      repeat (SETTLE + 20) cyc();

      // Illegal request (flagged only with the check built in), then a legal one.
      cfg_req = 8'h03;
      repeat (6) cyc();
      cfg_req = 8'h63;
      repeat (SETTLE + 2 * GAP + 10) cyc();

      // Random requests with assorted hold times and occasional resets.
      for (int i = 0; i < 60; i++) begin
         int hold;
         cfg_req = 8'($urandom);
         case ($urandom_range(0, 3))
            0:       hold = $urandom_range(1, 3);
            1:       hold = $urandom_range(5, 20);
            2:       hold = $urandom_range(20, 60);
            default: hold = SETTLE + 2 * GAP + 5;
         endcase
         repeat (hold) cyc();
         if ($urandom_range(0, 14) == 0) begin
            res = 1'b1;
            cyc();
            res = 1'b0;
         end
      end
      cfg_req = 8'h00;
      repeat (SETTLE + 2 * GAP + 10) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
